// File: rtl/bip_pkg.sv
// Shared BIP encodings: opcodes, datapath select/op codes and control FSM states.
// The accumulator datapath imports the same constants so both ends agree on encodings.
package bip_pkg;

    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] SELA_DM  = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    localparam logic SELB_IMM = 1'b0;
    localparam logic SELB_DM  = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

endpackage

// File: rtl/bip_decoder.sv
// Opcode decoder: turns the registered opcode into datapath selects and memory strobes.
// Everything is forced inactive unless the control FSM is in EXEC.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       exec,
    output logic [1:0] sel_a,
    output logic       sel_b,
    output logic       op,
    output logic       wr_acc,
    output logic       wr_ram,
    output logic       rd_ram,
    output logic       illegal
);

    always_comb begin
        sel_a   = SELA_DM;
        sel_b   = SELB_IMM;
        op      = OP_ADD;
        wr_acc  = 1'b0;
        wr_ram  = 1'b0;
        rd_ram  = 1'b0;
        illegal = 1'b0;
        if (exec) begin
            case (opcode)
                OPC_HLT: ;
                OPC_STO: wr_ram = 1'b1;
                OPC_LD: begin
                    sel_a  = SELA_DM;
                    wr_acc = 1'b1;
                    rd_ram = 1'b1;
                end
                OPC_LDI: begin
                    sel_a  = SELA_IMM;
                    wr_acc = 1'b1;
                end
                OPC_ADD, OPC_SUB: begin
                    sel_a  = SELA_ALU;
                    sel_b  = SELB_DM;
                    op     = (opcode == OPC_SUB) ? OP_SUB : OP_ADD;
                    wr_acc = 1'b1;
                    rd_ram = 1'b1;
                end
                OPC_ADDI, OPC_SUBI: begin
                    sel_a  = SELA_ALU;
                    sel_b  = SELB_IMM;
                    op     = (opcode == OPC_SUBI) ? OP_SUB : OP_ADD;
                    wr_acc = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/bip_control.sv
// BIP fetch/control stage: PC, IR, FETCH/EXEC sequencer, cycle counter and sticky
// illegal-opcode flag. Control outputs are decoded from IR so they are stable all of EXEC.
module bip_control
    import bip_pkg::*;
#(
    parameter int PC_W   = 11,
    parameter int DATA_W = 16,
    parameter int OPC_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] PM_DATA,
    output logic [PC_W-1:0]   PM_ADDR,
    output logic [PC_W-1:0]   OPERAND,
    output logic [1:0]        SEL_A,
    output logic              SEL_B,
    output logic              OP,
    output logic              WR_ACC,
    output logic              WR_RAM,
    output logic              RD_RAM,
    output logic              HALTED,
    output logic              ILLEGAL,
    output logic [CNT_W-1:0]  CYCLE_COUNT
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ill_q, ill_d;

    logic [OPC_W-1:0]  opcode;
    logic              exec;
    logic [1:0]        dec_sel_a;
    logic              dec_sel_b, dec_op, dec_wr_acc, dec_wr_ram, dec_rd_ram, dec_illegal;

    assign opcode = ir_q[DATA_W-1 -: OPC_W];
    assign exec   = (state_q == ST_EXEC);

    bip_decoder u_decoder (
        .opcode  (opcode),
        .exec    (exec),
        .sel_a   (dec_sel_a),
        .sel_b   (dec_sel_b),
        .op      (dec_op),
        .wr_acc  (dec_wr_acc),
        .wr_ram  (dec_wr_ram),
        .rd_ram  (dec_rd_ram),
        .illegal (dec_illegal)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: if (START) state_d = ST_FETCH;
            ST_FETCH:         state_d = ST_EXEC;
            ST_EXEC:          state_d = (opcode == OPC_HLT) ? ST_HALT : ST_FETCH;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q  <= '0;
            ir_q  <= '0;
            cnt_q <= '0;
            ill_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            cnt_q <= cnt_d;
            ill_q <= ill_d;
        end
    end

    // Counter saturates rather than wrapping so long runs still read as "very long".
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        cnt_d = cnt_q;
        ill_d = ill_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (START) begin
                    pc_d  = '0;
                    cnt_d = '0;
                    ill_d = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d  = PM_DATA;
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
            ST_EXEC: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (opcode != OPC_HLT) pc_d = pc_q + 1'b1;
                if (dec_illegal) ill_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        PM_ADDR     = pc_q;
        OPERAND     = ir_q[PC_W-1:0];
        SEL_A       = dec_sel_a;
        SEL_B       = dec_sel_b;
        OP          = dec_op;
        WR_ACC      = dec_wr_acc;
        WR_RAM      = dec_wr_ram;
        RD_RAM      = dec_rd_ram;
        HALTED      = (state_q == ST_IDLE) || (state_q == ST_HALT);
        ILLEGAL     = ill_q;
        CYCLE_COUNT = cnt_q;
    end

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: an instruction-level program walker predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_bip_control;

    typedef struct packed {
        logic [10:0] pm_addr;
        logic [10:0] operand;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        op;
        logic        wr_acc;
        logic        wr_ram;
        logic        rd_ram;
        logic        halted;
        logic        illegal;
        logic [15:0] cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [15:0] PM_DATA = '0;
    logic [10:0] PM_ADDR, OPERAND;
    logic [1:0]  SEL_A;
    logic        SEL_B, OP, WR_ACC, WR_RAM, RD_RAM, HALTED, ILLEGAL;
    logic [15:0] CYCLE_COUNT;

    bip_control #(.PC_W(11), .DATA_W(16), .OPC_W(5), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .PM_DATA(PM_DATA),
        .PM_ADDR(PM_ADDR), .OPERAND(OPERAND), .SEL_A(SEL_A), .SEL_B(SEL_B), .OP(OP),
        .WR_ACC(WR_ACC), .WR_RAM(WR_RAM), .RD_RAM(RD_RAM), .HALTED(HALTED),
        .ILLEGAL(ILLEGAL), .CYCLE_COUNT(CYCLE_COUNT)
    );

    always #5 CLK = ~CLK;

    logic [15:0] pmem [2048];
    always @(posedge CLK) #1 PM_DATA = pmem[PM_ADDR];

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    int          m_pc;
    logic [15:0] m_ir;
    int          m_cnt;
    bit          m_ill;
    bit          m_halted;

    function automatic exp_t sample();
        exp_t a;
        a = '{pm_addr: PM_ADDR, operand: OPERAND, sel_a: SEL_A, sel_b: SEL_B, op: OP,
              wr_acc: WR_ACC, wr_ram: WR_RAM, rd_ram: RD_RAM, halted: HALTED,
              illegal: ILLEGAL, cnt: CYCLE_COUNT};
        return a;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = sample();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s @%0t actual=%h required=%h (addr/opnd/selA/selB/op/wacc/wram/rram/halt/ill/cnt)",
                         name, $time, a, e);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) check("cycle", sb.pop_front());
        end
    end

    function automatic exp_t quiet();
        exp_t e;
        e = '0;
        e.pm_addr = m_pc[10:0];
        e.operand = m_ir[10:0];
        e.halted  = m_halted;
        e.illegal = m_ill;
        e.cnt     = m_cnt[15:0];
        return e;
    endfunction

    function automatic exp_t with_decode(input exp_t base, input logic [4:0] o);
        exp_t e;
        e = base;
        case (o)
            5'd1: e.wr_ram = 1'b1;
            5'd2: begin e.sel_a = 2'd0; e.wr_acc = 1'b1; e.rd_ram = 1'b1; end
            5'd3: begin e.sel_a = 2'd1; e.wr_acc = 1'b1; end
            5'd4, 5'd6: begin
                e.sel_a = 2'd2; e.sel_b = 1'b1; e.op = (o == 5'd6);
                e.wr_acc = 1'b1; e.rd_ram = 1'b1;
            end
            5'd5, 5'd7: begin
                e.sel_a = 2'd2; e.sel_b = 1'b0; e.op = (o == 5'd7); e.wr_acc = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Called at negedge+1: drives START for the coming edge and predicts the cycle after it.
    task automatic cycle(input bit st, input exp_t e);
        START = st;
        sb.push_back(e);
        @(negedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, quiet());
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = '0; m_cnt = 0; m_ill = 1'b0; m_halted = 1'b1;
    endtask

    task automatic run(input int max_cyc, input int glitch, input bit rst_on_sto);
        int c;
        logic [4:0] opc;
        c = 0;
        m_pc = 0; m_cnt = 0; m_ill = 1'b0; m_halted = 1'b0;
        cycle(1'b1, quiet());
        while (c < max_cyc) begin
            m_ir  = pmem[m_pc];
            m_cnt = sat(m_cnt);
            opc   = m_ir[15:11];
            cycle(c == glitch, with_decode(quiet(), opc));
            c++;
            if (rst_on_sto && opc == 5'd1) begin
                RESET = 1'b0;
                START = 1'b0;
                #1;
                model_reset();
                check("async_reset", quiet());
                @(negedge CLK);
                #1;
                RESET = 1'b1;
                return;
            end
            m_cnt = sat(m_cnt);
            if (opc == 5'd0) begin
                m_halted = 1'b1;
                cycle(c == glitch, quiet());
                return;
            end
            m_pc = (m_pc + 1) % 2048;
            if (opc >= 5'd8) m_ill = 1'b1;
            cycle(c == glitch, quiet());
            c++;
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] a);
        return {o, a};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) pmem[i] = '0;
    endtask

    initial begin
        clear_mem();
        model_reset();
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        idle(20);

        pmem[0] = ins(5'd3, 11'd5);
        pmem[1] = ins(5'd5, 11'd3);
        pmem[2] = ins(5'd1, 11'd10);
        pmem[3] = ins(5'd0, 11'd0);
        run(100, -1, 1'b0);
        idle(3);

        clear_mem();
        pmem[0] = ins(5'd2, 11'd4);
        pmem[1] = ins(5'd6, 11'd5);
        pmem[2] = ins(5'd0, 11'd0);
        run(100, 1, 1'b0);
        idle(3);

        clear_mem();
        pmem[0] = ins(5'b01010, 11'd7);
        pmem[1] = ins(5'd0, 11'd0);
        run(100, -1, 1'b0);
        idle(5);

        clear_mem();
        pmem[0] = ins(5'd3, 11'd5);
        pmem[1] = ins(5'd5, 11'd3);
        pmem[2] = ins(5'd1, 11'd10);
        pmem[3] = ins(5'd0, 11'd0);
        run(100, 2, 1'b1);
        idle(3);

        for (int r = 0; r < 30; r++) begin
            int len;
            clear_mem();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                logic [4:0] o;
                o = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31))
                                                : 5'($urandom_range(1, 7));
                pmem[i] = ins(o, 11'($urandom));
            end
            pmem[len] = ins(5'd0, 11'($urandom));
            run(100, $urandom_range(0, 2 * len + 1), ($urandom_range(0, 3) == 0));
            idle($urandom_range(1, 4));
        end

        for (int i = 0; i < 2048; i++) pmem[i] = ins(5'd5, 11'(i));
        pmem[2047] = ins(5'b01010, 11'd0);
        run(70000, -1, 1'b0);
        RESET = 1'b0;
        START = 1'b0;
        #1;
        model_reset();
        check("final_reset", quiet());
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        idle(4);
        @(negedge CLK);
        #1;

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bip_control.md
# bip_control

Instruction-fetch and control stage of the BIP processor, directly upstream of the accumulator datapath. Holds the program counter and instruction register, fetches 16-bit words from synchronous program memory, and decodes the 5-bit opcode into the datapath's mux selects, accumulator write enable and ALU op, plus the data-memory strobes. Runs a two-cycle FETCH/EXEC loop from START until an HLT instruction.

## Interface
- PC_W, 11: program counter, operand and data-memory address width
- DATA_W, 16: instruction width
- OPC_W, 5: opcode width, taken from the top of the instruction as [DATA_W-1 -: OPC_W]
- CNT_W, 16: cycle counter width

- CLK  in  1  single clock; all state changes on the rising edge
- RESET  in  1  asynchronous, active-low reset
- START  in  1  one-cycle pulse; starts or restarts the program at address 0
- PM_DATA  in  DATA_W  program memory read data, valid one cycle after PM_ADDR
- PM_ADDR  out  PC_W  program memory address (= PC)
- OPERAND  out  PC_W  instruction [PC_W-1:0]; datapath immediate and data-memory address
- SEL_A  out  2  accumulator source: 0 = DM_IN, 1 = immediate, 2 = ALU
- SEL_B  out  1  ALU B operand: 0 = immediate, 1 = DM_IN
- OP  out  1  ALU op: 0 = add, 1 = subtract
- WR_ACC  out  1  accumulator write enable
- WR_RAM  out  1  data-memory write strobe
- RD_RAM  out  1  data-memory read strobe
- HALTED  out  1  high in IDLE and HALT
- ILLEGAL  out  1  sticky flag: undefined opcode executed
- CYCLE_COUNT  out  CNT_W  clocks spent outside IDLE/HALT since the last START

## Operation
- States: IDLE (after reset), FETCH, EXEC, HALT.
- IDLE/HALT + START -> FETCH; PC, CYCLE_COUNT and ILLEGAL are cleared. START in FETCH/EXEC is ignored.
- FETCH: PM_ADDR = PC; control outputs inactive. -> EXEC, with IR <= PM_DATA on the transition edge.
- EXEC: outputs are decoded from IR; PC <= PC + 1, wrapping from 2^PC_W-1 to 0. -> FETCH, or -> HALT if the opcode is HLT. PC does not advance on HLT.
- Decode (opcode: SEL_A/SEL_B/OP/WR_ACC/WR_RAM/RD_RAM):
  - HLT 00000: all write/read strobes 0
  - STO 00001: WR_RAM = 1
  - LD 00010: SEL_A = 0, WR_ACC = 1, RD_RAM = 1
  - LDI 00011: SEL_A = 1, WR_ACC = 1
  - ADD 00100: SEL_A = 2, SEL_B = 1, OP = 0, WR_ACC = 1, RD_RAM = 1
  - ADDI 00101: SEL_A = 2, SEL_B = 0, OP = 0, WR_ACC = 1
  - SUB 00110: as ADD with OP = 1
  - SUBI 00111: as ADDI with OP = 1
- Opcodes 01000–11111 execute as NOP: strobes 0, PC advances, ILLEGAL is set and stays set until the next START.
- Outside EXEC, WR_ACC, WR_RAM and RD_RAM are 0, and SEL_A, SEL_B and OP are 0.
- OPERAND tracks IR at all times.
- CYCLE_COUNT increments in every FETCH and EXEC cycle and saturates at 2^CNT_W-1.

## Timing
- Reset values: state IDLE, PC 0, IR 0, all strobes and selects 0, HALTED 1, ILLEGAL 0, CYCLE_COUNT 0.
- RESET asserted mid-instruction forces the reset values immediately, without waiting for a clock. A WR_RAM in flight is dropped.
- Program memory is synchronous with one-cycle latency: PM_ADDR is driven in FETCH and PM_DATA is sampled at the end of FETCH.
- Data memory is asynchronous-read. DM_IN is valid within EXEC.
- The datapath captures the accumulator on the falling edge within EXEC, so the control outputs must be glitch-free registered or decoded-from-register values that are stable from the rising edge.
- STO writes the accumulator value from the previous instruction at the rising edge that ends EXEC.
- Throughput is 2 cycles per instruction. An N-instruction program ending in HLT reaches HALT 2N cycles after START, with CYCLE_COUNT = 2N.

## Structure
- Shared package bip_pkg holds:
  - opcode localparams
  - SEL_A encodings (SELA_DM, SELA_IMM, SELA_ALU)
  - SEL_B and OP encodings
  - state encodings
- The datapath uses the same SEL and OP constants.
- One combinational sub-module, bip_decoder: IR opcode + EXEC flag in; selects, strobes and illegal flag out.
- PC, IR, FSM and counter stay in bip_control.

## Test plan
- Reset with no START -> HALTED = 1, PM_ADDR = 0, all strobes 0, and they stay so for 20 cycles.
- START; program LDI 5, ADDI 3, STO 10, HLT -> EXEC cycles show in order:
  - SEL_A = 1, WR_ACC = 1
  - SEL_A = 2, SEL_B = 0, OP = 0
  - WR_RAM = 1, OPERAND = 10
  - HALT with PC = 3, CYCLE_COUNT = 8
- LD 4, SUB 5, HLT -> RD_RAM = 1 on both loads, SEL_B = 1, OP = 1 on SUB, WR_ACC = 1 on both.
- Opcode 01010 followed by HLT -> no strobes on 01010, ILLEGAL = 1 until the next START, PC advances past it.
- Preload PC = 2047 with a NOP at 2047 -> next PM_ADDR = 0. Separately, run a 70000-cycle loop -> CYCLE_COUNT holds at 65535.
- Assert RESET low during EXEC of STO -> WR_RAM drops before the next edge, state IDLE. START in mid-run -> ignored; START in HALT -> restarts at PC 0.
